// File: rtl/window_line_buffer.sv
// Sliding-window line buffer: stores raster rows in a circular bank of M+STRIDE rows
// and presents an M x N pixel window in parallel, stepping by STRIDE in both directions.
module window_line_buffer #(
  parameter int DW     = 8,
  parameter int M      = 3,
  parameter int N      = 4,
  parameter int W      = 512,
  parameter int STRIDE = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DW-1:0]     i_data,
  input  logic              i_data_valid,
  output logic              o_ready,
  output logic [M*N*DW-1:0] o_data,
  output logic              o_valid,
  input  logic              i_rd_data,
  output logic              o_band_done
);

  localparam int NBANK      = M + STRIDE;
  localparam int CW         = (W > 1) ? $clog2(W) : 1;
  localparam int BW         = $clog2(NBANK);
  localparam int FW         = $clog2(NBANK + 1);
  localparam int LAST_START = W - N;

  logic [DW-1:0] mem_r [NBANK][W];

  logic [CW-1:0] wr_col_r;
  logic [BW-1:0] wr_bank_r;
  logic [CW-1:0] rd_col_r;
  logic [BW-1:0] rd_bank_r;
  logic [FW-1:0] full_rows_r;
  logic          band_done_r;

  logic          accept_s;
  logic          pop_s;
  logic          row_end_s;
  logic          band_end_s;
  logic [FW-1:0] full_next_s;

  // Offsets used here never exceed NBANK-1, so one conditional subtraction is a full modulo.
  function automatic logic [BW-1:0] bank_add(input logic [BW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NBANK) begin
      sum = sum - NBANK;
    end else begin
      sum = sum;
    end
    return BW'(sum);
  endfunction

  assign o_ready     = (full_rows_r < FW'(NBANK));
  assign o_valid     = (full_rows_r >= FW'(M));
  assign o_band_done = band_done_r;

  assign accept_s   = i_data_valid && o_ready;
  assign pop_s      = i_rd_data && o_valid;
  assign row_end_s  = (wr_col_r == CW'(W - 1));
  assign band_end_s = ((int'(rd_col_r) + STRIDE) > LAST_START);

  // Window assembly: oldest row and leftmost pixel land in the most significant lane.
  always_comb begin
    o_data = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        o_data[((M-1-i)*N + (N-1-j))*DW +: DW] = mem_r[bank_add(rd_bank_r, i)][rd_col_r + CW'(j)];
      end
    end
  end

  // Row occupancy: a completed row and a band release may coincide in one cycle.
  always_comb begin
    full_next_s = full_rows_r;
    if (accept_s && row_end_s) begin
      full_next_s = full_next_s + FW'(1);
    end else begin
      full_next_s = full_next_s;
    end
    if (pop_s && band_end_s) begin
      full_next_s = full_next_s - FW'(STRIDE);
    end else begin
      full_next_s = full_next_s;
    end
  end

  // Pixel storage, intentionally without reset.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      mem_r[wr_bank_r][wr_col_r] <= i_data;
    end
  end

  // Write pointer: column within the row, then advance to the next bank at row end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_col_r  <= '0;
      wr_bank_r <= '0;
    end else if (accept_s) begin
      if (row_end_s) begin
        wr_col_r  <= '0;
        wr_bank_r <= bank_add(wr_bank_r, 1);
      end else begin
        wr_col_r  <= wr_col_r + CW'(1);
      end
    end
  end

  // Read pointer, occupancy and the band-done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_col_r    <= '0;
      rd_bank_r   <= '0;
      full_rows_r <= '0;
      band_done_r <= 1'b0;
    end else begin
      full_rows_r <= full_next_s;
      band_done_r <= pop_s && band_end_s;
      if (pop_s) begin
        if (band_end_s) begin
          rd_col_r  <= '0;
          rd_bank_r <= bank_add(rd_bank_r, STRIDE);
        end else begin
          rd_col_r  <= rd_col_r + CW'(STRIDE);
        end
      end
    end
  end

endmodule
